coin_encoder: RTL and testbench
===============================

// Module: coin_encoder
// PURPOSE
//   Coin-acceptor front end. Drives the 2-bit coin bus into the vending FSM.
//   Measures the width of the raw coin-sensor pulse and classifies it as a 5 (2'b01) or a 10 (2'b10).
//   Emits each accepted coin as a single-cycle code and holds it back while a vend (nw_pa) is in progress.
//   It holds coins back because the FSM discards any coin that arrives in its vend state.
//   Rejects bad pulses and coins that arrive while a coin is already waiting.
// PARAMETERS
//   CNT_W    8   width of pulse-width counter; saturates at 2**CNT_W-1
//   GLITCH   2   pulses shorter than GLITCH cycles are ignored silently (no reject)
//   N5_MIN   10  min width (cycles, inclusive) classified as 5
//   N5_MAX   20  max width (inclusive) classified as 5
//   N10_MIN  30  min width (inclusive) classified as 10
//   N10_MAX  45  max width (inclusive) classified as 10; N5_MAX < N10_MIN required
//   GAP      2   minimum number of coin==2'b00 cycles forced after each emitted code
// PORTS
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   sensor       in   1  raw coin sensor; high while a coin passes; asynchronous
//   nw_pa        in   1  vend indication from the vending FSM; high = vend in progress
//   coin         out  2  coin code: 00 none, 01 five, 10 ten; 11 is never driven
//   coin_reject  out  1  1-cycle pulse: coin returned (bad width or pending slot full)
//   busy         out  1  high while measuring, a coin is pending, or the GAP counter is nonzero
// BEHAVIOUR
//   Reset (rst_n=0, async): coin=00, coin_reject=0, busy=0, FSM=IDLE, counters=0, pending empty.
//     Synchronizer flops reset to 0. All outputs are registered.
//   Synchronizer: sensor passes through 2 flops into s_sync.
//     Edge detect compares s_sync with a delayed copy (s_d).
//   FSM IDLE: on rising edge of s_sync go to MEASURE, width counter=1.
//   FSM MEASURE: while s_sync=1, counter increments and saturates at max.
//     On the falling edge of s_sync, classify using width W and return to IDLE in the same cycle.
//   Classification of width W, applied in the falling-edge cycle:
//     - W < GLITCH: ignored, no output.
//     - N5_MIN <= W <= N5_MAX: code 01.
//     - N10_MIN <= W <= N10_MAX: code 10.
//     - Any other width, including saturated: coin_reject=1 on the next cycle.
//   Pending slot, depth 1: a valid code loads the slot at the classification edge.
//     If the slot is already full, the new coin is rejected and the held coin is unchanged.
//   Emit: at each edge, if slot full AND nw_pa=0 AND gap counter=0, then:
//     - coin <= slot for exactly 1 cycle;
//     - the slot is cleared;
//     - the gap counter is loaded with GAP.
//     Otherwise coin <= 00.
//     Emit and a new classification can occur at the same edge: the slot then reloads with the new code.
//     No reject occurs in that case.
//   Gap counter: decrements by 1 per cycle down to 0. It does not block measurement, only emission.
//   Latency: falling edge of s_sync seen at cycle T -> slot loaded at T+1.
//     Earliest coin!=00 is in cycle T+2 when nw_pa=0 and gap=0.
//     Total sensor pin fall to coin output is 4 cycles.
//   nw_pa=1 holds the pending coin indefinitely. Emission happens on the first eligible edge after nw_pa falls.
//   Reset mid-measure or with a coin pending discards the coin. No reject pulse is produced.
//   busy = (FSM==MEASURE) | slot_full | (gap!=0).
// TESTING
//   1) Sensor high 15 cycles, nw_pa=0 -> exactly one cycle coin=01, 4 cycles after the sensor falls; coin_reject=0.
//   2) Sensor high 40 cycles -> one cycle coin=10. Sensor high 25 cycles -> coin stays 00, coin_reject pulses once.
//   3) Sensor high 1 cycle -> no coin, no reject, busy drops 2 cycles after the pulse.
//      Sensor held high 300 cycles -> counter saturates -> reject.
//   4) nw_pa=1, insert a 5 coin, then a 10 coin -> second is rejected.
//      Drop nw_pa -> coin=01 emitted on the first eligible edge after nw_pa falls.
//   5) Two 5 coins 3 cycles apart with nw_pa=0 -> two separate 01 pulses with at least GAP=2 cycles of 00 between them.
//      Coin is never 11.
//   6) Assert rst_n=0 during MEASURE and with a coin pending -> outputs 00/0/0 immediately.
//      No coin is emitted after release.

Source files
------------

// File: rtl/coin_encoder.sv
// Coin-sensor pulse-width classifier feeding a one-entry coin slot to the vending FSM.
// Sensor fall to coin out is 4 cycles; the held coin waits while nw_pa=1 and for GAP idle cycles after each code.
module coin_encoder #(
  parameter int CNT_W   = 8,
  parameter int GLITCH  = 2,
  parameter int N5_MIN  = 10,
  parameter int N5_MAX  = 20,
  parameter int N10_MIN = 30,
  parameter int N10_MAX = 45,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic       nw_pa,
  output logic [1:0] coin,
  output logic       coin_reject,
  output logic       busy
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GLITCH_C  = CNT_W'(GLITCH);
  localparam logic [CNT_W-1:0] N5_MIN_C  = CNT_W'(N5_MIN);
  localparam logic [CNT_W-1:0] N5_MAX_C  = CNT_W'(N5_MAX);
  localparam logic [CNT_W-1:0] N10_MIN_C = CNT_W'(N10_MIN);
  localparam logic [CNT_W-1:0] N10_MAX_C = CNT_W'(N10_MAX);
  localparam logic [GAP_W-1:0] GAP_C     = GAP_W'(GAP);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, s_sync_q, s_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_vld_q, slot_vld_d;
  logic [1:0]       slot_dat_q, slot_dat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       coin_q, coin_d;
  logic             rej_q, rej_d;
  logic             busy_q, busy_d;

  logic       s_rise;
  logic       emit;
  logic       is5, is10, glitch;
  logic [1:0] code;

  assign s_rise = s_sync_q & ~s_d_q;
  assign emit   = slot_vld_q & ~nw_pa & (gap_q == '0);

  // A saturated count is never a valid coin, even if the window reaches the top.
  assign is5    = (cnt_q >= N5_MIN_C)  && (cnt_q <= N5_MAX_C)  && (cnt_q != CNT_MAX);
  assign is10   = (cnt_q >= N10_MIN_C) && (cnt_q <= N10_MAX_C) && (cnt_q != CNT_MAX);
  assign glitch = (cnt_q < GLITCH_C);
  assign code   = is5 ? 2'b01 : 2'b10;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_vld_d = slot_vld_q;
    slot_dat_d = slot_dat_q;
    gap_d      = gap_q;
    coin_d     = 2'b00;
    rej_d      = 1'b0;

    if (emit) begin
      coin_d     = slot_dat_q;
      slot_vld_d = 1'b0;
      gap_d      = GAP_C;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (s_rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (s_sync_q) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          // A slot being emitted this edge is free to take the new coin.
          if (is5 || is10) begin
            if (slot_vld_q && !emit) begin
              rej_d = 1'b1;
            end else begin
              slot_vld_d = 1'b1;
              slot_dat_d = code;
            end
          end else if (!glitch) begin
            rej_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MEASURE) | slot_vld_d | (gap_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      s_sync_q   <= 1'b0;
      s_d_q      <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      slot_vld_q <= 1'b0;
      slot_dat_q <= 2'b00;
      gap_q      <= '0;
      coin_q     <= 2'b00;
      rej_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sensor;
      s_sync_q   <= sync1_q;
      s_d_q      <= s_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_vld_q <= slot_vld_d;
      slot_dat_q <= slot_dat_d;
      gap_q      <= gap_d;
      coin_q     <= coin_d;
      rej_q      <= rej_d;
      busy_q     <= busy_d;
    end
  end

  assign coin        = coin_q;
  assign coin_reject = rej_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_coin_encoder.sv
// Directed bench for coin_encoder: widths, rejects, hold-off under nw_pa, gap spacing, reset.
module tb_coin_encoder;

  logic       clk;
  logic       rst_n;
  logic       sensor;
  logic       nw_pa;
  logic [1:0] coin;
  logic       coin_reject;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n11      = 0;
  int coin_cyc[$];
  int coin_val[$];
  int rej_cyc[$];
  int f1, f2, fd;

  coin_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor     (sensor),
    .nw_pa      (nw_pa),
    .coin       (coin),
    .coin_reject(coin_reject),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log what the outputs show there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (coin != 2'b00) begin
      coin_cyc.push_back(cyc);
      coin_val.push_back(int'(coin));
    end
    if (coin == 2'b11) n11++;
    if (coin_reject) rej_cyc.push_back(cyc);
  endtask

  task automatic clr();
    coin_cyc.delete();
    coin_val.delete();
    rej_cyc.delete();
    n11 = 0;
  endtask

  // Sensor high for n cycles; returns the cycle at which it was driven low.
  task automatic pulse(input int n, output int fall);
    sensor = 1'b1;
    repeat (n) tick();
    sensor = 1'b0;
    fall = cyc;
  endtask

  initial begin
    rst_n  = 1'b0;
    sensor = 1'b0;
    nw_pa  = 1'b0;
    repeat (3) tick();
    chk("reset_coin", coin, 0);
    chk("reset_rej", coin_reject, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1) width 15 -> one 01 four cycles after the fall
    clr();
    pulse(15, f1);
    repeat (10) tick();
    chk("t1_ncoin", coin_cyc.size(), 1);
    chk("t1_val", coin_val[0], 1);
    chk("t1_lat", coin_cyc[0] - f1, 4);
    chk("t1_rej", rej_cyc.size(), 0);
    chk("t1_busy_end", busy, 0);

    // 2) width 40 -> 10; width 25 -> reject only
    clr();
    pulse(40, f1);
    repeat (10) tick();
    chk("t2a_ncoin", coin_cyc.size(), 1);
    chk("t2a_val", coin_val[0], 2);
    chk("t2a_lat", coin_cyc[0] - f1, 4);
    chk("t2a_rej", rej_cyc.size(), 0);
    clr();
    pulse(25, f1);
    repeat (10) tick();
    chk("t2b_ncoin", coin_cyc.size(), 0);
    chk("t2b_nrej", rej_cyc.size(), 1);
    chk("t2b_rej_lat", rej_cyc[0] - f1, 3);

    // 3) 1-cycle glitch: silent, short busy; 300-cycle saturation: reject
    clr();
    pulse(1, f1);
    tick(); chk("t3_busy_f1", busy, 0);
    tick(); chk("t3_busy_f2", busy, 1);
    tick(); chk("t3_busy_f3", busy, 0);
    repeat (6) tick();
    chk("t3_ncoin", coin_cyc.size(), 0);
    chk("t3_rej", rej_cyc.size(), 0);
    clr();
    pulse(300, f1);
    chk("t3_busy_sat", busy, 1);
    repeat (8) tick();
    chk("t3s_ncoin", coin_cyc.size(), 0);
    chk("t3s_nrej", rej_cyc.size(), 1);
    chk("t3s_rej_lat", rej_cyc[0] - f1, 3);

    // 4) nw_pa holds a 5; a following 10 is rejected; 5 goes out when nw_pa drops
    clr();
    nw_pa = 1'b1;
    pulse(15, f1);
    repeat (8) tick();
    chk("t4_held", coin_cyc.size(), 0);
    chk("t4_busy_held", busy, 1);
    pulse(40, f2);
    repeat (8) tick();
    chk("t4_ncoin_held", coin_cyc.size(), 0);
    chk("t4_nrej", rej_cyc.size(), 1);
    chk("t4_rej_lat", rej_cyc[0] - f2, 3);
    nw_pa = 1'b0;
    fd = cyc;
    repeat (6) tick();
    chk("t4_ncoin", coin_cyc.size(), 1);
    chk("t4_val", coin_val[0], 1);
    chk("t4_emit_lat", coin_cyc[0] - fd, 1);
    chk("t4_busy_end", busy, 0);

    // 5) two 5 coins, 3 low cycles between sensor pulses
    clr();
    pulse(15, f1);
    repeat (3) tick();
    pulse(15, f2);
    repeat (10) tick();
    chk("t5_ncoin", coin_cyc.size(), 2);
    chk("t5_val0", coin_val[0], 1);
    chk("t5_val1", coin_val[1], 1);
    chk("t5_lat0", coin_cyc[0] - f1, 4);
    chk("t5_lat1", coin_cyc[1] - f2, 4);
    chk("t5_gap_ok", (coin_cyc[1] - coin_cyc[0] - 1) >= 2, 1);
    chk("t5_rej", rej_cyc.size(), 0);
    chk("t5_n11", n11, 0);

    // 6a) reset in the middle of a measurement
    clr();
    sensor = 1'b1;
    repeat (8) tick();
    chk("t6a_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6a_coin", coin, 0);
    chk("t6a_rej", coin_reject, 0);
    chk("t6a_busy", busy, 0);
    sensor = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    clr();
    repeat (10) tick();
    chk("t6a_ncoin", coin_cyc.size(), 0);
    chk("t6a_nrej", rej_cyc.size(), 0);

    // 6b) reset with a coin pending
    clr();
    nw_pa = 1'b1;
    pulse(15, f1);
    repeat (6) tick();
    chk("t6b_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6b_coin", coin, 0);
    chk("t6b_rej", coin_reject, 0);
    chk("t6b_busy", busy, 0);
    nw_pa = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    clr();
    repeat (10) tick();
    chk("t6b_ncoin", coin_cyc.size(), 0);
    chk("t6b_nrej", rej_cyc.size(), 0);
    chk("t6b_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
